demux_load_seq: RTL and testbench
=================================

// Module: demux_load_seq
// PURPOSE
//  Load sequencer directly upstream of the 1:8 pixel demux. Accepts a stream
//  of 15-bit source pixels over a valid/ready handshake and drives the demux.
//  Drive signals are the data word, column switch and row select, plus a
//  one-hot capture strobe. Each group of 8 pixels fills one 4-row x 2-column
//  window. The sequencer then raises win_valid to the bicubic kernel and holds
//  it until the kernel acknowledges.
// PARAMETERS
//  DATA_W   15  pixel width; matches demux data width
//  CNT_W    16  width of the completed-window counter
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  rst        in   1        synchronous reset, active-high
//  pix_in     in   DATA_W   source pixel
//  pix_valid  in   1        pix_in valid
//  pix_ready  out  1        sequencer can accept pix_in this cycle
//  flush      in   1        abort the current window; restart at slot 0
//  demux_in   out  DATA_W   registered pixel to demux data input
//  switch     out  1        registered column select (0 = col 0, 1 = col 1)
//  mux_sel    out  2        registered row select 0..3
//  load_en    out  8        one-hot capture strobe; bit = mux_sel*2 + switch
//  win_valid  out  1        full 4x2 window captured downstream
//  win_ack    in   1        kernel consumed window
//  win_cnt    out  CNT_W    number of completed (acked) windows, wraps
// BEHAVIOUR
//  Clock and reset
//  - Single clock. Reset is synchronous and active-high.
//  - Reset values: state FILL, slot=0, pix_ready=0 during rst and 1 the cycle
//    after, demux_in=0, switch=0, mux_sel=0, load_en=0, win_valid=0, win_cnt=0.
//  Accept and fill order
//  - Accept = pix_valid & pix_ready. slot (3b) counts accepted pixels.
//  - Fill order is column-major: slots 0-3 -> col 0, rows 0-3; slots 4-7 ->
//    col 1, rows 0-3. switch=slot[2], mux_sel=slot[1:0].
//  - Latency 1: pixel accepted at edge N appears on demux_in/switch/mux_sel
//    with its single load_en bit during cycle N+1.
//  - load_en is 0 in every cycle with no preceding accept.
//  - demux_in, switch and mux_sel hold their last values when idle (no
//    X/latch hazard downstream).
//  FSM
//  - FILL: pix_ready=1. Accept increments slot. Accept at slot 7 -> LAST,
//    slot wraps to 0.
//  - LAST: one cycle, pix_ready=0, the slot-7 strobe is issued -> WAIT.
//  - WAIT: win_valid=1, pix_ready=0. win_ack -> FILL next cycle, win_valid=0,
//    win_cnt+1 (wraps at 2^CNT_W).
//  Boundaries
//  - win_valid rises exactly one cycle after the last load_en pulse.
//  - win_ack outside WAIT is ignored. win_ack held high re-arms nothing extra:
//    one window per ack edge in WAIT only.
//  - pix_valid in LAST/WAIT: not accepted; source must hold data (standard
//    valid/ready).
//  - flush (any state): next cycle FILL, slot=0, win_valid=0, load_en=0,
//    win_cnt unchanged.
//  - flush has priority over an accept or ack in the same cycle; that pixel
//    or ack is discarded.
//  - rst has priority over flush. Reset mid-fill discards the partial window.
// STRUCTURE
//  - Shared package: DATA_W default, slot-to-(switch,mux_sel) mapping
//    function, FSM state encoding (FILL/LAST/WAIT as 2-bit localparams).
//  - Single module. No sub-module; one-hot decode is inline (3->8).
// TESTING
//  1 Reset: rst=1 two cycles -> all outputs 0. Cycle after release:
//    pix_ready=1.
//  2 Full fill: 8 back-to-back pixels 0x0001..0x0008 -> load_en 01,02,04,..
//    wrong; required order 0x01,0x04,0x10,0x40,0x02,0x08,0x20,0x80 with
//    demux_in matching. win_valid high the cycle after 0x80.
//  3 Backpressure: in WAIT hold pix_valid=1 (0x7FFF) 5 cycles -> pix_ready=0,
//    no load_en. Ack -> 0x7FFF accepted next FILL cycle with load_en=0x01.
//  4 Gapped input: pix_valid toggling 1/0 -> load_en only after accepts.
//    Window completes after 8 accepts; win_cnt 0->1 on ack.
//  5 Flush at slot 5 together with an accept -> no load_en next cycle;
//    next accept gives load_en=0x01, win_cnt unchanged.
//  6 Wrap: force 2^16 acks (CNT_W=16) -> win_cnt returns to 0.
//    Reset during WAIT -> win_valid=0 next cycle.
```

Note: test 2 contains a leftover drafting slip ("load_en 01,02,04,.. wrong;"). The corrected line is:

```verilog
//  2 Full fill: 8 back-to-back pixels 0x0001..0x0008 -> load_en sequence
//    0x01,0x04,0x10,0x40,0x02,0x08,0x20,0x80 with demux_in 1..8. win_valid
//    high the cycle after the 0x80 strobe.

Source files
------------

// File: rtl/demux_load_seq_pkg.sv
// Shared types and helpers for the demux load sequencer: FSM states and the
// slot -> (column, row) mapping that drives the 1:8 demux.
package demux_load_seq_pkg;

    localparam int DATA_W_DEF = 15;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        LAST = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic       sw;
        logic [1:0] sel;
    } pos_t;

    // Column-major fill: the low two slot bits walk the rows, bit 2 picks the column.
    function automatic pos_t slot_pos(input logic [2:0] slot);
        pos_t p;
        p.sw  = slot[2];
        p.sel = slot[1:0];
        return p;
    endfunction

    function automatic logic [7:0] strobe(input pos_t p);
        return 8'b1 << {p.sel, p.sw};
    endfunction

endpackage

// File: rtl/demux_load_seq_if.sv
// Pixel stream, demux drive and window handshake bundled for the load sequencer.
interface demux_load_seq_if
    import demux_load_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic [DATA_W-1:0] pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic              flush;
    logic [DATA_W-1:0] demux_in;
    logic              switch;
    logic [1:0]        mux_sel;
    logic [7:0]        load_en;
    logic              win_valid;
    logic              win_ack;
    logic [CNT_W-1:0]  win_cnt;

    modport master (
        output pix_in, pix_valid, flush, win_ack,
        input  pix_ready, demux_in, switch, mux_sel, load_en, win_valid, win_cnt
    );

    modport slave (
        input  pix_in, pix_valid, flush, win_ack,
        output pix_ready, demux_in, switch, mux_sel, load_en, win_valid, win_cnt
    );

endinterface

// File: rtl/demux_load_seq.sv
// Load sequencer ahead of the 1:8 pixel demux: fills a 4x2 window one pixel per
// accept, then presents win_valid to the kernel until it acks.
module demux_load_seq
    import demux_load_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    demux_load_seq_if.slave  bus
);

    state_t            state;
    logic [2:0]        slot;
    logic              pix_ready_q;
    logic [DATA_W-1:0] demux_in_q;
    logic              switch_q;
    logic [1:0]        mux_sel_q;
    logic [7:0]        load_en_q;
    logic              win_valid_q;
    logic [CNT_W-1:0]  win_cnt_q;

    logic accept;
    pos_t pos;

    assign accept = (state == FILL) && bus.pix_valid && pix_ready_q;
    assign pos    = slot_pos(slot);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            slot        <= 3'd0;
            pix_ready_q <= 1'b0;
            demux_in_q  <= '0;
            switch_q    <= 1'b0;
            mux_sel_q   <= 2'd0;
            load_en_q   <= 8'd0;
            win_valid_q <= 1'b0;
            win_cnt_q   <= '0;
        end else if (bus.flush) begin
            // Data/select lines keep their last value; only the strobe is killed.
            state       <= FILL;
            slot        <= 3'd0;
            pix_ready_q <= 1'b1;
            load_en_q   <= 8'd0;
            win_valid_q <= 1'b0;
        end else begin
            load_en_q <= 8'd0;
            case (state)
                FILL: begin
                    pix_ready_q <= 1'b1;
                    if (accept) begin
                        demux_in_q <= bus.pix_in;
                        switch_q   <= pos.sw;
                        mux_sel_q  <= pos.sel;
                        load_en_q  <= strobe(pos);
                        slot       <= slot + 3'd1;
                        if (slot == 3'd7) begin
                            state       <= LAST;
                            pix_ready_q <= 1'b0;
                        end
                    end
                end
                LAST: begin
                    state       <= WAIT;
                    pix_ready_q <= 1'b0;
                    win_valid_q <= 1'b1;
                end
                WAIT: begin
                    if (bus.win_ack) begin
                        state       <= FILL;
                        pix_ready_q <= 1'b1;
                        win_valid_q <= 1'b0;
                        win_cnt_q   <= win_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= FILL;
                    slot        <= 3'd0;
                    pix_ready_q <= 1'b0;
                    win_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pix_ready = pix_ready_q;
    assign bus.demux_in  = demux_in_q;
    assign bus.switch    = switch_q;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.load_en   = load_en_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_cnt   = win_cnt_q;

endmodule

// File: tb/tb_demux_load_seq.sv
// Directed bench for demux_load_seq: reset, fill order, backpressure, gaps,
// flush, counter wrap and reset during WAIT.
module tb_demux_load_seq;

    localparam int DW = 15;
    // win_cnt is narrowed so the wrap scenario fits a short run.
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux_load_seq_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    demux_load_seq #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [CW-1:0] exp_cnt;
    logic [7:0]    le_tab [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window();
        for (int i = 0; i < 8; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_in    = DW'(16'h0200 + i);
            step();
        end
        bus.pix_valid = 1'b0;
        step();
        bus.win_ack = 1'b1;
        step();
        bus.win_ack = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        bus.flush     = 1'b0;
        bus.win_ack   = 1'b0;
        step();
        step();
        vec_cnt++;
        if ({bus.pix_ready, bus.switch, bus.mux_sel, bus.win_valid} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_ctl: got rdy=%b sw=%b sel=%0d wv=%b, want all 0",
                     bus.pix_ready, bus.switch, bus.mux_sel, bus.win_valid);
        end
        vec_cnt++;
        if (bus.demux_in !== 15'h0 || bus.load_en !== 8'h0 || bus.win_cnt !== 4'h0) begin
            err_cnt++;
            $display("FAIL reset_data: got demux_in=%h load_en=%h win_cnt=%0d, want 0",
                     bus.demux_in, bus.load_en, bus.win_cnt);
        end
        rst = 1'b0;
        step();
        vec_cnt++;
        if (bus.pix_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_release_ready: got %b want 1", bus.pix_ready);
        end
        exp_cnt = '0;
    endtask

    task automatic test_full_fill();
        for (int i = 0; i < 8; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_in    = DW'(i + 1);
            step();
            vec_cnt++;
            if (bus.load_en !== le_tab[i] || bus.demux_in !== DW'(i + 1)) begin
                err_cnt++;
                $display("FAIL fill_%0d: got load_en=%h demux_in=%h want %h/%h",
                         i, bus.load_en, bus.demux_in, le_tab[i], i + 1);
            end
            vec_cnt++;
            if (bus.switch !== (i >= 4) || bus.mux_sel !== 2'(i % 4) || bus.win_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL fill_sel_%0d: got sw=%b sel=%0d wv=%b want %b/%0d/0",
                         i, bus.switch, bus.mux_sel, bus.win_valid, i >= 4, i % 4);
            end
        end
        vec_cnt++;
        if (bus.pix_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL fill_last_ready: got %b want 0", bus.pix_ready);
        end
        bus.pix_valid = 1'b0;
        step();
        vec_cnt++;
        if (bus.win_valid !== 1'b1 || bus.load_en !== 8'h00) begin
            err_cnt++;
            $display("FAIL fill_win_valid: got wv=%b load_en=%h want 1/00",
                     bus.win_valid, bus.load_en);
        end
    endtask

    task automatic test_backpressure();
        bus.pix_valid = 1'b1;
        bus.pix_in    = 15'h7FFF;
        for (int i = 0; i < 5; i++) begin
            step();
            vec_cnt++;
            if (bus.pix_ready !== 1'b0 || bus.load_en !== 8'h00 || bus.win_valid !== 1'b1) begin
                err_cnt++;
                $display("FAIL bp_hold_%0d: got rdy=%b load_en=%h wv=%b want 0/00/1",
                         i, bus.pix_ready, bus.load_en, bus.win_valid);
            end
        end
        bus.win_ack = 1'b1;
        step();
        bus.win_ack = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        vec_cnt++;
        if (bus.win_valid !== 1'b0 || bus.load_en !== 8'h00 || bus.win_cnt !== exp_cnt) begin
            err_cnt++;
            $display("FAIL bp_ack: got wv=%b load_en=%h win_cnt=%0d want 0/00/%0d",
                     bus.win_valid, bus.load_en, bus.win_cnt, exp_cnt);
        end
        step();
        vec_cnt++;
        if (bus.load_en !== 8'h01 || bus.demux_in !== 15'h7FFF) begin
            err_cnt++;
            $display("FAIL bp_resume: got load_en=%h demux_in=%h want 01/7fff",
                     bus.load_en, bus.demux_in);
        end
        bus.pix_valid = 1'b0;
        bus.flush     = 1'b1;
        step();
        bus.flush     = 1'b0;
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 8; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_in    = DW'(16'h0100 + i);
            step();
            vec_cnt++;
            if (bus.load_en !== le_tab[i] || bus.demux_in !== DW'(16'h0100 + i)) begin
                err_cnt++;
                $display("FAIL gap_acc_%0d: got load_en=%h demux_in=%h want %h/%h",
                         i, bus.load_en, bus.demux_in, le_tab[i], 16'h0100 + i);
            end
            bus.pix_valid = 1'b0;
            step();
            vec_cnt++;
            if (bus.load_en !== 8'h00 || bus.win_valid !== (i == 7)) begin
                err_cnt++;
                $display("FAIL gap_idle_%0d: got load_en=%h wv=%b want 00/%b",
                         i, bus.load_en, bus.win_valid, i == 7);
            end
        end
        // Ack held for three cycles must retire exactly one window.
        bus.win_ack = 1'b1;
        exp_cnt = exp_cnt + 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vec_cnt++;
            if (bus.win_cnt !== exp_cnt || bus.win_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL gap_ack_held_%0d: got win_cnt=%0d wv=%b want %0d/0",
                         i, bus.win_cnt, bus.win_valid, exp_cnt);
            end
        end
        bus.win_ack = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_in    = DW'(16'h0300 + i);
            step();
        end
        bus.pix_in = 15'h0555;
        bus.flush  = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.pix_valid = 1'b0;
        vec_cnt++;
        if (bus.load_en !== 8'h00 || bus.demux_in !== 15'h0304 || bus.pix_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL flush_cycle: got load_en=%h demux_in=%h rdy=%b want 00/0304/1",
                     bus.load_en, bus.demux_in, bus.pix_ready);
        end
        vec_cnt++;
        if (bus.win_cnt !== exp_cnt || bus.win_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_cnt: got win_cnt=%0d wv=%b want %0d/0",
                     bus.win_cnt, bus.win_valid, exp_cnt);
        end
        bus.pix_valid = 1'b1;
        bus.pix_in    = 15'h00AA;
        step();
        bus.pix_valid = 1'b0;
        vec_cnt++;
        if (bus.load_en !== 8'h01 || bus.demux_in !== 15'h00AA || bus.switch !== 1'b0 ||
            bus.mux_sel !== 2'd0) begin
            err_cnt++;
            $display("FAIL flush_restart: got load_en=%h demux_in=%h sw=%b sel=%0d want 01/00aa/0/0",
                     bus.load_en, bus.demux_in, bus.switch, bus.mux_sel);
        end
        bus.win_ack = 1'b1;
        step();
        bus.win_ack = 1'b0;
        vec_cnt++;
        if (bus.win_cnt !== exp_cnt) begin
            err_cnt++;
            $display("FAIL ack_in_fill: got win_cnt=%0d want %0d", bus.win_cnt, exp_cnt);
        end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        n = (1 << CW) - int'(exp_cnt);
        for (int w = 0; w < n; w++) run_window();
        vec_cnt++;
        if (bus.win_cnt !== 4'h0 || exp_cnt !== 4'h0) begin
            err_cnt++;
            $display("FAIL cnt_wrap: got win_cnt=%0d want 0", bus.win_cnt);
        end
        run_window();
        vec_cnt++;
        if (bus.win_cnt !== 4'h1) begin
            err_cnt++;
            $display("FAIL cnt_after_wrap: got win_cnt=%0d want 1", bus.win_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        for (int i = 0; i < 8; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_in    = DW'(i);
            step();
        end
        bus.pix_valid = 1'b0;
        step();
        vec_cnt++;
        if (bus.win_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL wait_entry: got wv=%b want 1", bus.win_valid);
        end
        rst = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        vec_cnt++;
        if (bus.win_valid !== 1'b0 || bus.win_cnt !== 4'h0 || bus.pix_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_in_wait: got wv=%b win_cnt=%0d rdy=%b want 0/0/0",
                     bus.win_valid, bus.win_cnt, bus.pix_ready);
        end
        rst = 1'b0;
        step();
        bus.pix_valid = 1'b1;
        bus.pix_in    = 15'h0042;
        step();
        bus.pix_valid = 1'b0;
        vec_cnt++;
        if (bus.load_en !== 8'h01 || bus.demux_in !== 15'h0042) begin
            err_cnt++;
            $display("FAIL rst_restart: got load_en=%h demux_in=%h want 01/0042",
                     bus.load_en, bus.demux_in);
        end
    endtask

    initial begin
        le_tab[0] = 8'h01; le_tab[1] = 8'h04; le_tab[2] = 8'h10; le_tab[3] = 8'h40;
        le_tab[4] = 8'h02; le_tab[5] = 8'h08; le_tab[6] = 8'h20; le_tab[7] = 8'h80;
        exp_cnt = '0;
        test_reset();
        test_full_fill();
        test_backpressure();
        test_gapped();
        test_flush();
        test_wrap();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
